// File: rtl/dcache_8x4_if.sv
// Bundles the CPU-side and memory-side signals of the 8x4 direct-mapped data cache.
// slave is the cache's view; master is the environment's (CPU plus main memory) view.
interface dcache_8x4_if;
   logic        READ;
   logic        WRITE;
   logic [7:0]  ADDRESS;
   logic [7:0]  WRITEDATA;
   logic [7:0]  READDATA;
   logic        BUSYWAIT;
   logic        MEM_READ;
   logic        MEM_WRITE;
   logic [5:0]  MEM_ADDRESS;
   logic [31:0] MEM_WRITEDATA;
   logic [31:0] MEM_READDATA;
   logic        MEM_BUSYWAIT;

   modport slave (
      input  READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
      output READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
   );

   modport master (
      output READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
      input  READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
   );
endinterface

// File: rtl/dcache_8x4.sv
// Direct-mapped, write-back, write-allocate byte cache: 8 blocks of 4 bytes.
// Misses stall the CPU while whole blocks are written back and refilled over the memory port.
module dcache_8x4 (
   input logic         CLK,
   input logic         RESET,
   dcache_8x4_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      FETCH     = 2'd2
   } state_t;

   function automatic logic [7:0] byte_sel(input logic [31:0] blk, input logic [1:0] off);
      return blk[{off, 3'b000} +: 8];
   endfunction

   function automatic logic [31:0] byte_merge(input logic [31:0] blk, input logic [1:0] off,
                                              input logic [7:0] val);
      logic [31:0] res;
      res = blk;
      res[{off, 3'b000} +: 8] = val;
      return res;
   endfunction

   state_t      state_r;
   logic [7:0]  valid_r;
   logic [7:0]  dirty_r;
   logic [2:0]  tag_r  [8];
   logic [31:0] data_r [8];
   logic        mem_read_r;
   logic        mem_write_r;
   logic [5:0]  mem_address_r;
   logic [31:0] mem_writedata_r;

   logic [2:0]  tag_s;
   logic [2:0]  index_s;
   logic [1:0]  offset_s;
   logic [31:0] line_s;
   logic        req_s;
   logic        hit_s;
   logic        miss_s;
   logic        victim_dirty_s;

   // Address decode and hit/miss detection for the current CPU request
   always_comb begin
      tag_s          = bus.ADDRESS[7:5];
      index_s        = bus.ADDRESS[4:2];
      offset_s       = bus.ADDRESS[1:0];
      line_s         = data_r[index_s];
      req_s          = bus.READ | bus.WRITE;
      hit_s          = valid_r[index_s] && (tag_r[index_s] == tag_s);
      miss_s         = req_s && !hit_s;
      victim_dirty_s = valid_r[index_s] && dirty_r[index_s];
   end

   assign bus.READDATA      = byte_sel(line_s, offset_s);
   assign bus.BUSYWAIT      = (state_r != IDLE) || miss_s;
   assign bus.MEM_READ      = mem_read_r;
   assign bus.MEM_WRITE     = mem_write_r;
   assign bus.MEM_ADDRESS   = mem_address_r;
   assign bus.MEM_WRITEDATA = mem_writedata_r;

   // Controller FSM, block arrays and registered memory-port requests
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_r         <= IDLE;
         valid_r         <= 8'h00;
         dirty_r         <= 8'h00;
         mem_read_r      <= 1'b0;
         mem_write_r     <= 1'b0;
         mem_address_r   <= 6'd0;
         mem_writedata_r <= 32'd0;
         for (int i = 0; i < 8; i++) begin
            tag_r[i]  <= 3'd0;
            data_r[i] <= 32'd0;
         end
      end else begin
         case (state_r)
            IDLE: begin
               if (miss_s) begin
                  if (victim_dirty_s) begin
                     state_r         <= WRITEBACK;
                     mem_write_r     <= 1'b1;
                     mem_address_r   <= {tag_r[index_s], index_s};
                     mem_writedata_r <= line_s;
                  end else begin
                     state_r       <= FETCH;
                     mem_read_r    <= 1'b1;
                     mem_address_r <= {tag_s, index_s};
                  end
               end else if (bus.WRITE && hit_s) begin
                  // A store with READ also high is a store
                  data_r[index_s]  <= byte_merge(line_s, offset_s, bus.WRITEDATA);
                  dirty_r[index_s] <= 1'b1;
               end else begin
                  state_r <= IDLE;
               end
            end
            WRITEBACK: begin
               if (!bus.MEM_BUSYWAIT) begin
                  state_r       <= FETCH;
                  mem_write_r   <= 1'b0;
                  mem_read_r    <= 1'b1;
                  mem_address_r <= {tag_s, index_s};
               end else begin
                  state_r <= WRITEBACK;
               end
            end
            FETCH: begin
               if (!bus.MEM_BUSYWAIT) begin
                  state_r          <= IDLE;
                  mem_read_r       <= 1'b0;
                  data_r[index_s]  <= bus.MEM_READDATA;
                  tag_r[index_s]   <= tag_s;
                  valid_r[index_s] <= 1'b1;
                  dirty_r[index_s] <= 1'b0;
               end else begin
                  state_r <= FETCH;
               end
            end
            default: begin
               state_r     <= IDLE;
               mem_read_r  <= 1'b0;
               mem_write_r <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_dcache_8x4.sv
// Randomized bench for dcache_8x4: a flat byte-memory view of the CPU plus a block-state
// reference predicts load data, hit/miss, write-backs and stall lengths.
module tb_dcache_8x4;
   logic CLK = 1'b0;
   logic RESET = 1'b1;

   dcache_8x4_if bus ();

   dcache_8x4 dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Backing store held by the memory responder and the CPU-visible byte image
   logic [31:0] mem  [64];
   logic [7:0]  flat [256];
   // Reference block state: which memory block each cache slot holds and whether it is dirty
   bit          m_valid [8];
   bit          m_dirty [8];
   logic [2:0]  m_tag   [8];

   int          lat_force = -1;
   int          excl_viol = 0;
   int          ev_kind [$];
   int          ev_addr [$];
   logic [31:0] ev_data [$];
   int          ev_lat  [$];
   int          last_wb_addr;
   logic [31:0] last_wb_data;
   int          last_fetch_addr;

   // Main-memory responder: busy for a chosen latency, then low for one completing cycle
   initial begin
      bit act;
      int cnt;
      int cur_lat;
      act = 1'b0;
      cnt = 0;
      cur_lat = 0;
      bus.MEM_BUSYWAIT = 1'b0;
      bus.MEM_READDATA = 32'd0;
      forever begin
         @(negedge CLK);
         if (bus.MEM_READ && bus.MEM_WRITE) excl_viol++;
         if (bus.MEM_READ || bus.MEM_WRITE) begin
            if (!act) begin
               act = 1'b1;
               cur_lat = (lat_force >= 0) ? lat_force : int'($urandom_range(0, 4));
               cnt = cur_lat;
            end
            if (cnt > 0) begin
               bus.MEM_BUSYWAIT = 1'b1;
               cnt--;
            end else begin
               bus.MEM_BUSYWAIT = 1'b0;
               act = 1'b0;
               if (bus.MEM_WRITE) begin
                  mem[bus.MEM_ADDRESS] = bus.MEM_WRITEDATA;
                  ev_kind.push_back(1);
                  ev_data.push_back(bus.MEM_WRITEDATA);
               end else begin
                  bus.MEM_READDATA = mem[bus.MEM_ADDRESS];
                  ev_kind.push_back(0);
                  ev_data.push_back(mem[bus.MEM_ADDRESS]);
               end
               ev_addr.push_back(int'(bus.MEM_ADDRESS));
               ev_lat.push_back(cur_lat);
            end
         end else begin
            act = 1'b0;
            bus.MEM_BUSYWAIT = 1'b0;
         end
      end
   end

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
         m_tag[i]   = 3'd0;
      end
      for (int a = 0; a < 256; a++) flat[a] = mem[a / 4][(a % 4) * 8 +: 8];
   endtask

   // One CPU access, started just after a rising edge and returning just after one
   task automatic access(input bit wr, input bit both, input logic [7:0] a,
                         input logic [7:0] wd, output int stall);
      logic [2:0]  idx;
      logic [2:0]  tg;
      logic [5:0]  vb;
      logic [31:0] exp_wb;
      bit          hit;
      bit          wb;
      bit          done;
      int          n_ev;
      int          exp_stall;
      idx = a[4:2];
      tg  = a[7:5];
      hit = m_valid[idx] && (m_tag[idx] == tg);
      wb  = !hit && m_valid[idx] && m_dirty[idx];
      vb  = {m_tag[idx], idx};
      exp_wb = {flat[{vb, 2'd3}], flat[{vb, 2'd2}], flat[{vb, 2'd1}], flat[{vb, 2'd0}]};
      ev_kind.delete();
      ev_addr.delete();
      ev_data.delete();
      ev_lat.delete();
      bus.READ      = !wr || both;
      bus.WRITE     = wr;
      bus.ADDRESS   = a;
      bus.WRITEDATA = wd;
      stall = 0;
      done  = 1'b0;
      for (int c = 0; c < 200 && !done; c++) begin
         @(negedge CLK);
         if (bus.BUSYWAIT) stall++;
         else done = 1'b1;
      end
      check("access_done", {31'd0, done}, 32'd1);
      if (!wr) check("readdata", {24'd0, bus.READDATA}, {24'd0, flat[a]});
      n_ev = hit ? 0 : (wb ? 2 : 1);
      check("mem_xfers", ev_kind.size(), n_ev);
      exp_stall = hit ? 0 : 1;
      foreach (ev_lat[i]) exp_stall += ev_lat[i] + 1;
      check("stall", stall, exp_stall);
      if (ev_kind.size() == n_ev && n_ev > 0) begin
         if (wb) begin
            check("wb_kind", ev_kind[0], 1);
            check("wb_addr", ev_addr[0], {26'd0, vb});
            check("wb_data", ev_data[0], exp_wb);
            last_wb_addr = ev_addr[0];
            last_wb_data = ev_data[0];
         end
         check("fetch_kind", ev_kind[n_ev - 1], 0);
         check("fetch_addr", ev_addr[n_ev - 1], {26'd0, tg, idx});
         last_fetch_addr = ev_addr[n_ev - 1];
      end
      @(posedge CLK);
      #1;
      bus.READ  = 1'b0;
      bus.WRITE = 1'b0;
      if (!hit) begin
         m_valid[idx] = 1'b1;
         m_tag[idx]   = tg;
         m_dirty[idx] = 1'b0;
      end
      if (wr) begin
         flat[a]      = wd;
         m_dirty[idx] = 1'b1;
      end
   endtask

   initial begin
      int st;
      bus.READ      = 1'b0;
      bus.WRITE     = 1'b0;
      bus.ADDRESS   = 8'd0;
      bus.WRITEDATA = 8'd0;
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      mem[0] = 32'h44332211;
      #1 RESET = 1'b0;
      #2;
      check("rst_mem_read", {31'd0, bus.MEM_READ}, 32'd0);
      check("rst_mem_write", {31'd0, bus.MEM_WRITE}, 32'd0);
      check("rst_mem_addr", {26'd0, bus.MEM_ADDRESS}, 32'd0);
      check("rst_mem_wdata", bus.MEM_WRITEDATA, 32'd0);
      check("rst_busy_idle", {31'd0, bus.BUSYWAIT}, 32'd0);
      bus.READ = 1'b1;
      #1;
      check("rst_busy_req", {31'd0, bus.BUSYWAIT}, 32'd1);
      bus.READ = 1'b0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RESET = 1'b1;
      model_reset();
      @(posedge CLK);
      #1;

      // Clean miss with a 3-cycle busy memory
      lat_force = 3;
      access(1'b0, 1'b0, 8'h00, 8'h00, st);
      check("tp_miss_stall", st, 32'd5);
      check("tp_miss_fetch", last_fetch_addr, 32'h00);
      lat_force = -1;
      access(1'b0, 1'b0, 8'h03, 8'h00, st);
      check("tp_hit_stall", st, 32'd0);
      access(1'b1, 1'b0, 8'h02, 8'hAB, st);
      check("tp_whit_stall", st, 32'd0);
      access(1'b0, 1'b0, 8'h02, 8'h00, st);
      // Conflict with the dirty block 0
      access(1'b0, 1'b0, 8'h20, 8'h00, st);
      check("tp_wb_addr", last_wb_addr, 32'h00);
      check("tp_wb_data", last_wb_data, 32'h44AB2211);
      check("tp_wb_fetch", last_fetch_addr, 32'h08);
      access(1'b1, 1'b0, 8'h45, 8'h5A, st);
      check("tp_walloc_fetch", last_fetch_addr, 32'h11);
      access(1'b0, 1'b0, 8'h45, 8'h00, st);
      access(1'b0, 1'b0, 8'h05, 8'h00, st);
      check("tp_walloc_wb_addr", last_wb_addr, 32'h11);
      check("tp_walloc_wb_byte", {24'd0, last_wb_data[15:8]}, 32'h5A);

      // Reset in the middle of a fetch
      lat_force = 10;
      bus.READ = 1'b1;
      bus.ADDRESS = 8'h80;
      repeat (3) @(negedge CLK);
      check("midfetch_req", {31'd0, bus.MEM_READ}, 32'd1);
      RESET = 1'b0;
      #1;
      check("midfetch_drop", {31'd0, bus.MEM_READ}, 32'd0);
      bus.READ = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      RESET = 1'b1;
      model_reset();
      @(posedge CLK);
      #1;
      lat_force = -1;
      access(1'b0, 1'b0, 8'h80, 8'h00, st);
      check("midfetch_remiss", {31'd0, st > 0}, 32'd1);

      // Random traffic over a few tags to mix hits, clean misses and dirty evictions
      for (int n = 0; n < 400; n++) begin
         bit          wr;
         bit          both;
         logic [7:0]  a;
         wr   = 1'($urandom_range(0, 1));
         both = wr && ($urandom_range(0, 7) == 0);
         a    = {1'b0, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31))};
         if ($urandom_range(0, 9) == 0) a[7] = 1'b1;
         access(wr, both, a, 8'($urandom), st);
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge CLK);
            #1;
         end
      end

      check("mem_excl", excl_viol, 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
